lut_ram_param: RTL and testbench
================================

// Module: lut_ram_param
// PURPOSE
//   Parametrised single-port RAM, successor to the fixed 8-bit LUT RAM. Adds configurable
//   width/depth, byte-lane write enables, registered read with selectable latency and
//   rd_valid_o strobe, and a post-reset hardware clear sequencer.
//   Sits as local scratch/buffer storage behind any datapath block on the clk_i domain.
// PARAMETERS
//   WIDTH      32    data word width in bits; must be a multiple of 8
//   DEPTH      256   number of words; need not be a power of 2
//   READ_LAT   1     read latency in cycles, legal values 1 or 2
//   CLEAR_VAL  0     WIDTH-bit value written to every word by the clear sequencer
//   AW         $clog2(DEPTH)  derived address width (localparam, not overridable)
// PORTS
//   clk_i        in   1          clock, all logic on rising edge
//   rst_i        in   1          reset, asynchronous, active-low
//   w_en_i       in   1          write request
//   r_en_i       in   1          read request
//   be_i         in   WIDTH/8    byte-lane write enables, bit k -> data_in[8k+7:8k]
//   address_i    in   AW         word address
//   data_in      in   WIDTH      write data
//   data_out     out  WIDTH      read data, registered
//   rd_valid_o   out  1          1-cycle strobe: data_out holds the requested word
//   busy_o       out  1          1 while clear sequence runs; requests ignored
//   addr_err_o   out  1          1-cycle strobe: accepted request had address_i >= DEPTH
// BEHAVIOUR
//   Reset (rst_i=0, async): state<=CLEAR, clr_cnt<=0, data_out<=0, rd_valid_o<=0,
//     busy_o<=1, addr_err_o<=0, read pipeline valid bits<=0. Array contents not reset.
//   FSM: CLEAR -> READY, no other transitions except reset.
//     CLEAR: each cycle mem[clr_cnt]<=CLEAR_VAL, clr_cnt++; when clr_cnt==DEPTH-1 is
//       written, next state READY. Takes exactly DEPTH cycles after rst_i deasserts.
//       busy_o=1 throughout; w_en_i/r_en_i ignored, no rd_valid_o/addr_err_o.
//     READY: busy_o=0; requests accepted every cycle, no backpressure.
//   Reset asserted mid-CLEAR or mid-read: restarts CLEAR from address 0; in-flight reads
//     dropped, no rd_valid_o issued for them.
//   Write (READY, w_en_i=1, address_i<DEPTH): at the edge, for each k with be_i[k]=1,
//     mem[address_i][8k+:8]<=data_in[8k+:8]; lanes with be_i[k]=0 unchanged.
//     be_i=0 with w_en_i=1 is a legal no-op.
//   Read (READY, r_en_i=1, address_i<DEPTH): sampled at edge N; data_out and rd_valid_o=1
//     valid after edge N+READ_LAT-1+1 (i.e. READ_LAT cycles after request edge).
//     Back-to-back reads give one result per cycle, in order.
//   data_out holds last read value when rd_valid_o=0 (no return to 0).
//   Simultaneous w_en_i and r_en_i, same address: read-first, returns pre-write data;
//     write still performed.
//   address_i >= DEPTH (non-power-of-2 DEPTH): write discarded; read returns 0 with
//     rd_valid_o=1 on the normal latency; addr_err_o=1 the cycle after the request.
//   No X on outputs after reset for any input sequence.
// TESTING
//   1 Reset then idle, DEPTH=16: busy_o=1 for exactly 16 cycles after rst_i rises, then 0;
//     read every address -> 0 (CLEAR_VAL).
//   2 WIDTH=32, write addr 5 data 32'hDEADBEEF be=4'b1111, then be=4'b0101 data 32'h11223344
//     -> read addr 5 = 32'hDE22BE44, rd_valid_o high one cycle at READ_LAT.
//   3 Same cycle write addr 3 = 32'hA5A5A5A5 and read addr 3 (prior 0) -> read 0;
//     next read addr 3 -> 32'hA5A5A5A5.
//   4 READ_LAT=2, reads addr 0,1,2 back-to-back -> three consecutive rd_valid_o cycles,
//     data in order, first valid 2 cycles after first request.
//   5 DEPTH=12, write addr 13 then read addr 13 -> addr_err_o pulses twice, read data 0,
//     addresses 0..11 unchanged.
//   6 Assert rst_i low at clear cycle 7 and during a pending read -> no rd_valid_o,
//     clear restarts, busy_o high for full DEPTH cycles after release.

Source files
------------

// File: rtl/lut_ram_param.sv
// Parametrised single-port scratch RAM with byte-lane writes, pipelined registered read,
// out-of-range address flagging and a post-reset hardware clear sequencer.
module lut_ram_param #(
  parameter int unsigned         WIDTH     = 32,
  parameter int unsigned         DEPTH     = 256,
  parameter int unsigned         READ_LAT  = 1,
  parameter logic [WIDTH-1:0]    CLEAR_VAL = '0,
  localparam int unsigned        AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 w_en_i,
  input  logic                 r_en_i,
  input  logic [WIDTH/8-1:0]   be_i,
  input  logic [AW-1:0]        address_i,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 rd_valid_o,
  output logic                 busy_o,
  output logic                 addr_err_o
);

  localparam int unsigned NB      = WIDTH / 8;
  localparam logic [AW:0]  DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            busy_d;
  logic            ready;
  logic            in_range;
  logic [WIDTH-1:0] rd_word;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [READ_LAT-1:0] rv_q;
  logic [WIDTH-1:0]    rd_q [READ_LAT];

  // State register for the clear sequencer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_o    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_o    <= busy_d;
    end
  end

  // Next-state: walk every address once, then hand over to normal operation
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy_d    = 1'b1;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == LAST) begin
          state_d   = ST_READY;
          busy_d    = 1'b0;
          clr_cnt_d = '0;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  assign ready    = (state_q == ST_READY);
  assign in_range = ({1'b0, address_i} < DEPTH_W);
  assign rd_word  = in_range ? mem[address_i] : '0;

  // Storage array; not reset, the clear sequencer initialises it
  always_ff @(posedge clk_i) begin
    if (!ready) begin
      mem[clr_cnt_q] <= CLEAR_VAL;
    end else if (w_en_i && in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) mem[address_i][8*k +: 8] <= data_in[8*k +: 8];
      end
    end
  end

  // Read pipeline: word captured at the request edge (read-first), then READ_LAT stages to data_out
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rv_q       <= '0;
      for (int i = 0; i < READ_LAT; i++) rd_q[i] <= '0;
      data_out   <= '0;
      rd_valid_o <= 1'b0;
      addr_err_o <= 1'b0;
    end else begin
      rv_q[0] <= ready && r_en_i;
      if (ready && r_en_i) rd_q[0] <= rd_word;
      for (int i = 1; i < READ_LAT; i++) begin
        rv_q[i] <= rv_q[i-1];
        rd_q[i] <= rd_q[i-1];
      end
      addr_err_o <= ready && (w_en_i || r_en_i) && !in_range;
      rd_valid_o <= rv_q[READ_LAT-1];
      if (rv_q[READ_LAT-1]) data_out <= rd_q[READ_LAT-1];
    end
  end

endmodule

// File: tb/tb_lut_ram_param.sv
// Bench for lut_ram_param: two instances (16 words / latency 1, 12 words / latency 2) on shared
// stimulus, each checked every cycle against a scheduled-result memory model.
module tb_lut_ram_param;

  localparam int DEPTH_A = 16;
  localparam int LAT_A   = 1;
  localparam int DEPTH_B = 12;
  localparam int LAT_B   = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        w_en_i = 1'b0;
  logic        r_en_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [3:0]  address_i = '0;
  logic [31:0] data_in = '0;

  logic [31:0] dout_a, dout_b;
  logic        vld_a, vld_b, busy_a, busy_b, err_a, err_b;

  always #5 clk_i = ~clk_i;

  lut_ram_param #(.WIDTH(32), .DEPTH(DEPTH_A), .READ_LAT(LAT_A)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .w_en_i(w_en_i), .r_en_i(r_en_i), .be_i(be_i),
    .address_i(address_i), .data_in(data_in), .data_out(dout_a), .rd_valid_o(vld_a),
    .busy_o(busy_a), .addr_err_o(err_a));

  lut_ram_param #(.WIDTH(32), .DEPTH(DEPTH_B), .READ_LAT(LAT_B)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .w_en_i(w_en_i), .r_en_i(r_en_i), .be_i(be_i),
    .address_i(address_i), .data_in(data_in), .data_out(dout_b), .rd_valid_o(vld_b),
    .busy_o(busy_b), .addr_err_o(err_b));

  // Reference model: word array per instance plus results scheduled by due cycle
  logic [31:0] mm [2][16];
  int          clr [2];
  logic        sv [2][4];
  logic [31:0] sd [2][4];
  logic [31:0] exp_d [2];
  logic        exp_v [2];
  logic        exp_err [2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    clr[0] = DEPTH_A;
    clr[1] = DEPTH_B;
    for (int i = 0; i < 2; i++) begin
      exp_d[i] = '0; exp_v[i] = 1'b0; exp_err[i] = 1'b0;
      for (int s = 0; s < 4; s++) sv[i][s] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int dp, lat, s;
    logic inr;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      exp_v[i] = 1'b0;
      exp_err[i] = 1'b0;
      if (rst_i) begin
        dp  = (i == 0) ? DEPTH_A : DEPTH_B;
        lat = (i == 0) ? LAT_A : LAT_B;
        if (clr[i] > 0) begin
          mm[i][dp - clr[i]] = '0;
          clr[i]--;
        end else begin
          inr = int'(address_i) < dp;
          exp_err[i] = (w_en_i | r_en_i) & ~inr;
          if (r_en_i) begin
            s = (cyc + lat) % 4;
            sv[i][s] = 1'b1;
            sd[i][s] = inr ? mm[i][address_i] : 32'h0;
          end
          if (w_en_i && inr)
            for (int k = 0; k < 4; k++)
              if (be_i[k]) mm[i][address_i][8*k +: 8] = data_in[8*k +: 8];
        end
        s = cyc % 4;
        if (sv[i][s]) begin
          exp_v[i] = 1'b1;
          exp_d[i] = sd[i][s];
          sv[i][s] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a_data"},  dout_a, exp_d[0]);
    chk({tag, ".a_valid"}, 32'(vld_a), 32'(exp_v[0]));
    chk({tag, ".a_busy"},  32'(busy_a), 32'(clr[0] > 0));
    chk({tag, ".a_err"},   32'(err_a), 32'(exp_err[0]));
    chk({tag, ".b_data"},  dout_b, exp_d[1]);
    chk({tag, ".b_valid"}, 32'(vld_b), 32'(exp_v[1]));
    chk({tag, ".b_busy"},  32'(busy_b), 32'(clr[1] > 0));
    chk({tag, ".b_err"},   32'(err_b), 32'(exp_err[1]));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_all(tag);
  endtask

  task automatic drive(input logic w, input logic r, input logic [3:0] be,
                       input logic [3:0] a, input logic [31:0] d, input string tag);
    w_en_i = w; r_en_i = r; be_i = be; address_i = a; data_in = d;
    cycle(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, tag);
  endtask

  // Asynchronous reset asserted mid-cycle, held for a few edges, released on a falling edge
  task automatic do_reset(input int hold, input string tag);
    rst_i = 1'b0; w_en_i = 1'b0; r_en_i = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(negedge clk_i);
    for (int i = 0; i < hold; i++) cycle({tag, ".hold"});
    rst_i = 1'b1;
  endtask

  // Counts edges seen with busy_o high, sampled just before each edge
  task automatic count_busy(input string tag);
    int ca = 0, cb = 0;
    for (int n = 0; n < 64; n++) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (!busy_a && !busy_b) break;
      cycle({tag, ".clr"});
    end
    chk({tag, ".a_busy_cycles"}, 32'(ca), 32'(DEPTH_A));
    chk({tag, ".b_busy_cycles"}, 32'(cb), 32'(DEPTH_B));
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++) mm[i][j] = '0;
    @(negedge clk_i);
    do_reset(2, "t1_reset");
    count_busy("t1");
    for (int a = 0; a < 16; a++) drive(1'b0, 1'b1, 4'h0, 4'(a), 32'h0, "t1_read_all");
    idle(3, "t1_drain");

    // Full write then partial byte-lane overwrite
    drive(1'b1, 1'b0, 4'hF, 4'd5, 32'hDEADBEEF, "t2_wr_full");
    drive(1'b1, 1'b0, 4'h5, 4'd5, 32'h11223344, "t2_wr_lanes");
    drive(1'b0, 1'b1, 4'h0, 4'd5, 32'h0, "t2_rd");
    idle(1, "t2_wait_a");
    chk("t2.a_word", dout_a, 32'hDE22BE44);
    chk("t2.a_strobe", 32'(vld_a), 32'd1);
    idle(1, "t2_wait_b");
    chk("t2.b_word", dout_b, 32'hDE22BE44);
    chk("t2.b_strobe", 32'(vld_b), 32'd1);
    chk("t2.a_strobe_single", 32'(vld_a), 32'd0);
    idle(2, "t2_drain");

    // Same-address write and read in one cycle returns pre-write data
    drive(1'b1, 1'b1, 4'hF, 4'd3, 32'hA5A5A5A5, "t3_wr_rd");
    idle(1, "t3_wait");
    chk("t3.a_old_word", dout_a, 32'h0);
    drive(1'b0, 1'b1, 4'h0, 4'd3, 32'h0, "t3_rd");
    idle(1, "t3_wait2");
    chk("t3.a_new_word", dout_a, 32'hA5A5A5A5);
    idle(2, "t3_drain");

    // Back-to-back reads
    for (int a = 0; a < 3; a++) drive(1'b1, 1'b0, 4'hF, 4'(a), 32'h100 + 32'(a), "t4_wr");
    for (int a = 0; a < 3; a++) drive(1'b0, 1'b1, 4'h0, 4'(a), 32'h0, "t4_rd");
    idle(3, "t4_drain");

    // Out-of-range access on the 12-word instance
    drive(1'b1, 1'b0, 4'hF, 4'd13, 32'hCAFEF00D, "t5_wr13");
    chk("t5.b_err_wr", 32'(err_b), 32'd1);
    drive(1'b0, 1'b1, 4'h0, 4'd13, 32'h0, "t5_rd13");
    chk("t5.b_err_rd", 32'(err_b), 32'd1);
    for (int a = 0; a < 12; a++) drive(1'b0, 1'b1, 4'h0, 4'(a), 32'h0, "t5_rd_all");
    idle(3, "t5_drain");

    // Reset during clear and during an in-flight read
    do_reset(1, "t6_rst1");
    for (int i = 0; i < 7; i++) cycle("t6_partial_clr");
    do_reset(2, "t6_rst_mid_clear");
    count_busy("t6a");
    drive(1'b1, 1'b0, 4'hF, 4'd1, 32'h55AA55AA, "t6_wr");
    drive(1'b0, 1'b1, 4'h0, 4'd1, 32'h0, "t6_rd_pending");
    do_reset(3, "t6_rst_mid_read");
    count_busy("t6b");
    drive(1'b0, 1'b1, 4'h0, 4'd1, 32'h0, "t6_rd_cleared");
    idle(3, "t6_drain");

    // Random traffic
    for (int n = 0; n < 400; n++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom, "rand");
    idle(3, "rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
